xs3_decoder: RTL and testbench

XS3_DECODER -- requirements
Module: xs3_decoder

---
 rtl/xs3_pkg.sv | 13 +
 rtl/xs3_digit_decode.sv | 15 +
 rtl/xs3_decoder.sv | 78 +++++++
 tb/tb_xs3_decoder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/xs3_pkg.sv
// Shared constants and types for the excess-3 frame decoder.
package xs3_pkg;

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'b0011;
  localparam logic [3:0] XS3_MAX    = 4'b1100;

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational excess-3 to BCD digit decode; invalid codes map to 0.
module xs3_digit_decode
  import xs3_pkg::*;
(
  input  logic [3:0] code,
  output logic [3:0] bcd,
  output logic       ok
);

  always_comb begin
    ok  = (code >= XS3_MIN) && (code <= XS3_MAX);
    bcd = ok ? (code - XS3_OFFSET) : 4'd0;
  end

endmodule

// File: rtl/xs3_decoder.sv
// Collects excess-3 digits into a packed BCD frame, MSD first, and holds
// the result until downstream acknowledges it.
module xs3_decoder
  import xs3_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_W,
  input  logic        in_X,
  input  logic        in_Y,
  input  logic        in_Z,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        out_ready,
  output logic [15:0] out_bcd,
  output logic [2:0]  out_count,
  output logic        out_err,
  output logic        out_valid,
  input  logic        in_ack
);

  localparam logic [2:0] LAST_IDX = 3'(NDIG - 1);

  state_t     state, state_nxt;
  logic [3:0] dig_bcd;
  logic       dig_ok;
  logic       accept, terminate, clear;

  xs3_digit_decode u_dec (
    .code ({in_W, in_X, in_Y, in_Z}),
    .bcd  (dig_bcd),
    .ok   (dig_ok)
  );

  assign accept    = in_valid & out_ready;
  // The NDIG-th digit closes the frame even without in_last.
  assign terminate = accept & (in_last | (out_count == LAST_IDX));
  assign clear     = (state == S_OUTPUT) & in_ack;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= S_COLLECT;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: if (terminate) state_nxt = S_OUTPUT;
      S_OUTPUT:  if (in_ack)    state_nxt = S_COLLECT;
      default:                  state_nxt = S_COLLECT;
    endcase
  end

  // Ready is held low while reset is asserted even though state is COLLECT.
  always_comb begin
    out_ready = (state == S_COLLECT) & in_rst_n;
    out_valid = (state == S_OUTPUT);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_bcd   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_bcd   <= {out_bcd[11:0], dig_bcd};
      out_count <= out_count + 3'd1;
      out_err   <= out_err | ~dig_ok;
    end else if (clear) begin
      out_bcd   <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xs3_decoder.sv
// Directed and randomized checks of xs3_decoder against a digit-queue model.
module tb_xs3_decoder;

  localparam int NDIG = 4;

  logic        in_clk = 1'b0;
  logic        in_rst_n = 1'b1;
  logic        in_W = 0, in_X = 0, in_Y = 0, in_Z = 0;
  logic        in_valid = 0, in_last = 0, in_ack = 0;
  logic        out_ready, out_err, out_valid;
  logic [15:0] out_bcd;
  logic [2:0]  out_count;

  int n_chk = 0;
  int n_fail = 0;

  int          digs[$];
  logic [15:0] exp_bcd;
  int          exp_cnt;
  logic        exp_err;

  xs3_decoder #(.NDIG(NDIG)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n),
    .in_W(in_W), .in_X(in_X), .in_Y(in_Y), .in_Z(in_Z),
    .in_valid(in_valid), .in_last(in_last),
    .out_ready(out_ready), .out_bcd(out_bcd), .out_count(out_count),
    .out_err(out_err), .out_valid(out_valid), .in_ack(in_ack)
  );

  always #5 in_clk = ~in_clk;

  function automatic int dval(input int c);
    return (c >= 3 && c <= 12) ? c - 3 : 0;
  endfunction

  function automatic logic [15:0] model_bcd();
    int v = 0;
    foreach (digs[i]) v = v * 16 + dval(digs[i]);
    return 16'(v);
  endfunction

  function automatic logic model_err();
    logic e = 0;
    foreach (digs[i]) if (digs[i] < 3 || digs[i] > 12) e = 1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk); #1;
  endtask

  task automatic send(input logic [3:0] code, input logic last);
    int g = 0;
    {in_W, in_X, in_Y, in_Z} = code;
    in_last = last;
    in_valid = 1;
    while (!out_ready && g < 50) begin tick(); g++; end
    chk("ready_wait", 16'(out_ready), 16'd1);
    tick();
    in_valid = 0;
    in_last = 0;
    digs.push_back(int'(code));
    if (last || digs.size() == NDIG) begin
      exp_bcd = model_bcd();
      exp_cnt = digs.size();
      exp_err = model_err();
      digs.delete();
      chk("valid_lat1", 16'(out_valid), 16'd1);
      chk("ready_out",  16'(out_ready), 16'd0);
      chk("frame_bcd",  out_bcd, exp_bcd);
      chk("frame_cnt",  16'(out_count), 16'(exp_cnt));
      chk("frame_err",  16'(out_err), 16'(exp_err));
    end else begin
      chk("part_valid", 16'(out_valid), 16'd0);
      chk("part_cnt",   16'(out_count), 16'(digs.size()));
      chk("part_bcd",   out_bcd, model_bcd());
    end
  endtask

  task automatic ack_frame(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 16'(out_valid), 16'd1);
      chk("hold_ready", 16'(out_ready), 16'd0);
      chk("hold_bcd",   out_bcd, exp_bcd);
      chk("hold_cnt",   16'(out_count), 16'(exp_cnt));
      chk("hold_err",   16'(out_err), 16'(exp_err));
    end
    in_ack = 1;
    tick();
    in_ack = 0;
    chk("ack_valid", 16'(out_valid), 16'd0);
    chk("ack_ready", 16'(out_ready), 16'd1);
    chk("ack_bcd",   out_bcd, 16'd0);
    chk("ack_cnt",   16'(out_count), 16'd0);
    chk("ack_err",   16'(out_err), 16'd0);
  endtask

  initial begin
    #2 in_rst_n = 0;
    #1;
    chk("rst_ready", 16'(out_ready), 16'd0);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_bcd",   out_bcd, 16'd0);
    chk("rst_cnt",   16'(out_count), 16'd0);
    chk("rst_err",   16'(out_err), 16'd0);
    tick(); tick();
    in_rst_n = 1;
    tick();
    chk("post_rst_ready", 16'(out_ready), 16'd1);

    // Four-digit frame with last on the 4th.
    send(4'b0110, 0); send(4'b1001, 0); send(4'b0100, 0); send(4'b1100, 1);
    chk("f1_bcd", out_bcd, 16'h3619);
    ack_frame(0);

    // Single zero digit.
    send(4'b0011, 1);
    chk("f2_bcd", out_bcd, 16'h0000);
    ack_frame(1);

    // Invalid code sets the error; next frame is clean.
    send(4'b0100, 0); send(4'b1111, 1);
    chk("f3_bcd", out_bcd, 16'h0010);
    chk("f3_err", 16'(out_err), 16'd1);
    ack_frame(0);
    send(4'b0101, 1);
    chk("f4_bcd", out_bcd, 16'h0002);
    chk("f4_err", 16'(out_err), 16'd0);

    // Held ack for 5 cycles.
    ack_frame(5);

    // Frame closes at NDIG; 5th digit waits through OUTPUT.
    send(4'b0011, 0); send(4'b0100, 0); send(4'b0101, 0); send(4'b0110, 0);
    chk("f5_bcd", out_bcd, 16'h0123);
    {in_W, in_X, in_Y, in_Z} = 4'b0111;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f5_stall_ready", 16'(out_ready), 16'd0);
      chk("f5_stall_bcd",   out_bcd, 16'h0123);
    end
    in_ack = 1;
    tick();
    in_ack = 0;
    chk("f5_ack_ready", 16'(out_ready), 16'd1);
    chk("f5_ack_cnt",   16'(out_count), 16'd0);
    tick();
    in_valid = 0;
    digs.push_back(7);
    chk("f6_first_cnt", 16'(out_count), 16'd1);
    chk("f6_first_bcd", out_bcd, 16'h0004);
    send(4'b0011, 1);
    chk("f6_bcd", out_bcd, 16'h0040);

    // Ack in COLLECT is ignored.
    ack_frame(0);
    send(4'b1000, 0);
    in_ack = 1;
    tick();
    in_ack = 0;
    chk("ack_in_collect_cnt",   16'(out_count), 16'd1);
    chk("ack_in_collect_valid", 16'(out_valid), 16'd0);

    // Reset mid-frame discards the partial data.
    send(4'b0111, 0);
    #2 in_rst_n = 0;
    #1;
    chk("mid_rst_bcd",   out_bcd, 16'd0);
    chk("mid_rst_cnt",   16'(out_count), 16'd0);
    chk("mid_rst_ready", 16'(out_ready), 16'd0);
    chk("mid_rst_valid", 16'(out_valid), 16'd0);
    digs.delete();
    tick();
    in_rst_n = 1;
    tick();
    send(4'b1000, 1);
    chk("f7_bcd", out_bcd, 16'h0005);
    chk("f7_cnt", 16'(out_count), 16'd1);
    ack_frame(0);

    // Randomized frames, gaps and ack delays.
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int d = 0; d < n; d++) begin
        logic [3:0] c;
        logic       l;
        c = 4'($urandom_range(0, 15));
        l = (d == n - 1);
        if ($urandom_range(0, 3) == 0) tick();
        send(c, l);
        if (out_valid) ack_frame($urandom_range(0, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
